// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the Sysbus memory arbiter.
//   arb_state_t  - arbiter FSM states (IDLE, ADDR, WDATA, RDATA)
//   BEATS        - data beats per cache-line transaction (512-bit line / 64)
//   WRITE_BIT    - index of the read/write flag in a default-width Sysbus tag
//   SYSBUS_WRITE - flag value that marks a write request
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  localparam int   BEATS        = 8;
  localparam int   WRITE_BIT    = 12;
  localparam logic SYSBUS_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select.
//   req  in  N   request vector
//   ptr  in  IW  index that has highest priority this round
//   gnt  out N   one-hot grant (all zero when nothing is requested)
//   idx  out IW  index of the granted requester (0 when nothing is requested)
// Tying ptr to 0 turns this into a fixed lowest-index-wins priority encoder.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin : sel
    logic found;
    int   cand;
    found = 1'b0;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    // Scan starting at ptr and wrapping; the first requester seen wins.
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single Sysbus DRAM port between NUM_REQ cache
// clients. One client owns the bus for a whole transaction (address phase
// plus BEATS data beats); after the grant all signals are routed
// combinationally between the owner and memory.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   c_reqcyc/c_reqack  per-client request valid / request+write-beat ack
//   c_req/c_reqtag     per-client address-or-write-data / tag, client i at [i*W +: W]
//   c_respcyc          per-client response valid
//   c_respack          per-client response ack
//   c_resp/c_resptag   response data/tag, broadcast to all clients
//   m_bus_*            memory side of the Sysbus
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to drop the round-robin pointer
// and let the lowest-index requester always win.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = WRITE_BIT + 1,
  parameter int NUM_REQ        = 2,
  parameter int BEATS          = mem_arb_pkg::BEATS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                c_reqcyc,
  output logic [NUM_REQ-1:0]                c_reqack,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] c_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  c_reqtag,
  output logic [NUM_REQ-1:0]                c_respcyc,
  input  logic [NUM_REQ-1:0]                c_respack,
  output logic [BUS_DATA_WIDTH-1:0]         c_resp,
  output logic [BUS_TAG_WIDTH-1:0]          c_resptag,
  output logic                              m_bus_reqcyc,
  input  logic                              m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]         m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          m_bus_reqtag,
  input  logic                              m_bus_respcyc,
  output logic                              m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]         m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]          m_bus_resptag
);

  localparam int W  = BUS_DATA_WIDTH;
  localparam int TW = BUS_TAG_WIDTH;
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          is_write_q, is_write_d;

  logic [NUM_REQ-1:0] win_gnt;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      arb_ptr;
  logic               win_is_write;

  logic               own_reqcyc;
  logic [W-1:0]       own_req;
  logic [TW-1:0]      own_reqtag;
  logic               own_respack;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  assign arb_ptr = rr_ptr_q;
`endif

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_arb (
    .req (c_reqcyc),
    .ptr (arb_ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign win_is_write = (c_reqtag[int'(win_idx)*TW + TW-1] == SYSBUS_WRITE);

  assign own_reqcyc  = c_reqcyc[owner_q];
  assign own_req     = c_req[int'(owner_q)*W +: W];
  assign own_reqtag  = c_reqtag[int'(owner_q)*TW +: TW];
  assign own_respack = c_respack[owner_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_q     <= '0;
      is_write_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      is_write_q <= is_write_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    beat_d        = beat_q;
    is_write_d    = is_write_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    c_reqack      = '0;
    c_respcyc     = '0;
    c_resp        = '0;
    c_resptag     = '0;

    unique case (state_q)
      IDLE: begin
        if (|win_gnt) begin
          owner_d    = win_idx;
          is_write_d = win_is_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
          if (int'(win_idx) == NUM_REQ - 1) rr_ptr_d = '0;
          else                              rr_ptr_d = win_idx + OW'(1);
`endif
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_bus_reqcyc      = own_reqcyc;
        m_bus_req         = own_req;
        m_bus_reqtag      = own_reqtag;
        c_reqack[owner_q] = m_bus_reqack;
        // A client that withdraws before the address is taken gives up
        // its grant; nothing reached memory.
        if (!own_reqcyc) begin
          state_d = IDLE;
        end else if (m_bus_reqack) begin
          beat_d  = '0;
          state_d = is_write_q ? WDATA : RDATA;
        end
      end

      WDATA: begin
        m_bus_reqcyc      = own_reqcyc;
        m_bus_req         = own_req;
        m_bus_reqtag      = own_reqtag;
        c_reqack[owner_q] = m_bus_reqack;
        if (own_reqcyc && m_bus_reqack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end

      RDATA: begin
        c_respcyc[owner_q] = m_bus_respcyc;
        m_bus_respack      = own_respack;
        c_resp             = m_bus_resp;
        c_resptag          = m_bus_resptag;
        if (m_bus_respcyc && own_respack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (2 clients, 64-bit data, 13-bit tags).
// Inputs are driven 1 ns after the rising edge and outputs are sampled 1 ns
// later, well away from the edge.
module tb_mem_bus_arbiter;

  localparam int W  = 64;
  localparam int TW = 13;
  localparam int N  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      c_reqcyc;
  logic [N-1:0]      c_reqack;
  logic [N*W-1:0]    c_req;
  logic [N*TW-1:0]   c_reqtag;
  logic [N-1:0]      c_respcyc;
  logic [N-1:0]      c_respack;
  logic [W-1:0]      c_resp;
  logic [TW-1:0]     c_resptag;
  logic              m_bus_reqcyc;
  logic              m_bus_reqack;
  logic [W-1:0]      m_bus_req;
  logic [TW-1:0]     m_bus_reqtag;
  logic              m_bus_respcyc;
  logic              m_bus_respack;
  logic [W-1:0]      m_bus_resp;
  logic [TW-1:0]     m_bus_resptag;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .c_reqcyc      (c_reqcyc),
    .c_reqack      (c_reqack),
    .c_req         (c_req),
    .c_reqtag      (c_reqtag),
    .c_respcyc     (c_respcyc),
    .c_respack     (c_respack),
    .c_resp        (c_resp),
    .c_resptag     (c_resptag),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in ADDR for client cl. Runs the address phase and
  // eight read beats; when stall_at >= 0, memory withholds respcyc for five
  // cycles before that beat. Returns with the DUT back in IDLE.
  task automatic read_txn(input int cl, input logic [63:0] addr, input bit drop,
                          input int stall_at, input string tg);
    logic [1:0] oh;
    oh = 2'b01 << cl;
    #1;
    chk({tg, "_addr_cyc"}, 64'(m_bus_reqcyc), 64'd1);
    chk({tg, "_addr"}, m_bus_req, addr);
    chk({tg, "_ack_before"}, 64'(c_reqack), 64'd0);
    m_bus_reqack = 1'b1;
    #1;
    chk({tg, "_addr_ack"}, 64'(c_reqack), 64'(oh));
    tick();
    m_bus_reqack = 1'b0;
    if (drop) c_reqcyc[cl] = 1'b0;
    #1;
    chk({tg, "_rd_no_req"}, 64'(m_bus_reqcyc), 64'd0);
    for (int b = 0; b < 8; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          m_bus_respcyc = 1'b0;
          #1;
          chk({tg, "_stall_respcyc"}, 64'(c_respcyc), 64'd0);
          tick();
        end
      end
      m_bus_respcyc = 1'b1;
      m_bus_resp    = addr + 64'(b);
      m_bus_resptag = 13'(b + 1);
      #1;
      chk({tg, "_beat_respcyc"}, 64'(c_respcyc), 64'(oh));
      chk({tg, "_beat_data"}, c_resp, addr + 64'(b));
      chk({tg, "_beat_tag"}, 64'(c_resptag), 64'(b + 1));
      chk({tg, "_beat_respack"}, 64'(m_bus_respack), 64'd1);
      tick();
    end
    // respcyc still high from the last beat: an IDLE arbiter must not route it.
    #1;
    chk({tg, "_end_idle"}, 64'(c_respcyc), 64'd0);
    m_bus_respcyc = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    c_reqcyc      = '0;
    c_req         = '0;
    c_reqtag      = '0;
    c_respack     = 2'b11;
    m_bus_reqack  = 1'b0;
    m_bus_respcyc = 1'b0;
    m_bus_resp    = '0;
    m_bus_resptag = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_m_reqcyc", 64'(m_bus_reqcyc), 64'd0);
    chk("rst_m_req", m_bus_req, 64'd0);
    chk("rst_m_reqtag", 64'(m_bus_reqtag), 64'd0);
    chk("rst_m_respack", 64'(m_bus_respack), 64'd0);
    chk("rst_c_reqack", 64'(c_reqack), 64'd0);
    chk("rst_c_respcyc", 64'(c_respcyc), 64'd0);

    // Single write, client 0: address then 0xA0..0xA7, 9 ack pulses total
    c_reqcyc      = 2'b01;
    c_req[63:0]   = 64'h2040;
    c_reqtag[12:0] = 13'h1003;
    pulses = 0;
    tick();
    #1;
    chk("wr_addr", m_bus_req, 64'h2040);
    chk("wr_addr_tag", 64'(m_bus_reqtag), 64'h1003);
    m_bus_reqack = 1'b1;
    #1;
    pulses += int'(c_reqack[0]);
    tick();
    for (int b = 0; b < 8; b++) begin
      c_req[63:0] = 64'hA0 + 64'(b);
      #1;
      chk("wr_beat_data", m_bus_req, 64'hA0 + 64'(b));
      chk("wr_beat_cyc", 64'(m_bus_reqcyc), 64'd1);
      pulses += int'(c_reqack[0]);
      tick();
    end
    c_reqcyc = 2'b00;
    #1;
    pulses += int'(c_reqack[0]);
    chk("wr_ack_pulses", 64'(pulses), 64'd9);
    chk("wr_idle_reqcyc", 64'(m_bus_reqcyc), 64'd0);
    m_bus_reqack = 1'b0;
    tick();

    // Single read, client 1 at 0x1000
    c_reqcyc         = 2'b10;
    c_req[127:64]    = 64'h1000;
    c_reqtag[25:13]  = 13'h0005;
    tick();
    read_txn(1, 64'h1000, 1'b1, -1, "rd1");

    // Contention: both request together with rr_ptr back at 0
    c_req[63:0]     = 64'h3000;
    c_reqtag[12:0]  = 13'h0001;
    c_req[127:64]   = 64'h4000;
    c_reqtag[25:13] = 13'h0002;
    c_reqcyc        = 2'b11;
    tick();
    read_txn(0, 64'h3000, 1'b1, -1, "cont0");
    chk("cont_idle_gap", 64'(m_bus_reqcyc), 64'd0);
    tick();
    read_txn(1, 64'h4000, 1'b1, -1, "cont1");

    // Fairness: both clients hold requests for four transactions
    c_req[63:0]   = 64'h5000;
    c_req[127:64] = 64'h6000;
    c_reqcyc      = 2'b11;
    tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
    read_txn(0, 64'h5000, 1'b0, -1, "fair0");
    tick();
    read_txn(0, 64'h5000, 1'b0, -1, "fair1");
    tick();
    read_txn(0, 64'h5000, 1'b0, -1, "fair2");
    tick();
    read_txn(0, 64'h5000, 1'b0, -1, "fair3");
`else
    read_txn(0, 64'h5000, 1'b0, -1, "fair0");
    tick();
    read_txn(1, 64'h6000, 1'b0, -1, "fair1");
    tick();
    read_txn(0, 64'h5000, 1'b0, -1, "fair2");
    tick();
    read_txn(1, 64'h6000, 1'b0, -1, "fair3");
`endif
    c_reqcyc = 2'b00;
    tick();

    // Stall: five idle cycles between beats 3 and 4
    c_req[127:64] = 64'h8000;
    c_reqcyc      = 2'b10;
    tick();
    read_txn(1, 64'h8000, 1'b1, 4, "stall");
    tick();

    // Reset after beat 4 of a read
    c_req[127:64] = 64'h7000;
    c_reqcyc      = 2'b10;
    tick();
    m_bus_reqack = 1'b1;
    tick();
    m_bus_reqack = 1'b0;
    c_reqcyc     = 2'b00;
    for (int b = 0; b < 5; b++) begin
      m_bus_respcyc = 1'b1;
      m_bus_resp    = 64'h7000 + 64'(b);
      #1;
      chk("rstmid_beat", c_resp, 64'h7000 + 64'(b));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_respcyc", 64'(c_respcyc), 64'd0);
    chk("rstmid_respack", 64'(m_bus_respack), 64'd0);
    chk("rstmid_reqcyc", 64'(m_bus_reqcyc), 64'd0);
    chk("rstmid_reqack", 64'(c_reqack), 64'd0);
    chk("rstmid_resp", c_resp, 64'd0);
    m_bus_respcyc = 1'b0;
    c_req[127:64] = 64'h7100;
    c_reqcyc      = 2'b10;
    tick();
    read_txn(1, 64'h7100, 1'b1, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
